// File: rtl/uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
// Contents:
//   REG_*          register offsets, compared against addr[3:2]
//   STATUS_*       bit positions inside the STATUS register
//   CTRL_*         bit positions inside the CTRL register
//   tx_state_e     shift FSM state encoding
//   div_sanitize   maps a written bit period of 0 to 1
package uart_tx_pkg;

   localparam logic [1:0] REG_TXDATA = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_DIV    = 2'd2;
   localparam logic [1:0] REG_CTRL   = 2'd3;

   localparam int STATUS_FULL_BIT  = 0;
   localparam int STATUS_EMPTY_BIT = 1;
   localparam int STATUS_BUSY_BIT  = 2;
   localparam int STATUS_COUNT_LSB = 8;

   localparam int CTRL_TX_EN_BIT  = 0;
   localparam int CTRL_IRQ_EN_BIT = 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_e;

   // A bit period of zero cycles is meaningless; the shortest legal period is one cycle.
   function automatic logic [15:0] div_sanitize(input logic [15:0] value);
      return (value == 16'd0) ? 16'd1 : value;
   endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Simple-system bus slot interface for the UART transmitter.
// Signals:
//   req    request, always granted
//   we     1 = write, 0 = read
//   be     byte enables
//   addr   byte address
//   wdata  write data
//   rvalid response valid, exactly one cycle after req
//   rdata  read data, valid with rvalid
//   err    error response, valid with rvalid
// Handshake: the master holds req high for one cycle per access together with we/be/addr/wdata;
// there is no back-pressure. The slave answers every request with rvalid high for exactly one
// cycle on the following cycle, with rdata and err valid in that same cycle.
interface uart_tx_if #(
   parameter int DataWidth    = 32,
   parameter int AddressWidth = 32
);

   logic                    req;
   logic                    we;
   logic [3:0]              be;
   logic [AddressWidth-1:0] addr;
   logic [DataWidth-1:0]    wdata;
   logic                    rvalid;
   logic [DataWidth-1:0]    rdata;
   logic                    err;

   modport master (
      output req, we, be, addr, wdata,
      input  rvalid, rdata, err
   );

   modport slave (
      input  req, we, be, addr, wdata,
      output rvalid, rdata, err
   );

endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO holding bytes waiting to be serialised.
// Ports:
//   clk_i, rst_ni  clock, synchronous active-low reset
//   push_i/wdata_i write one entry (ignored when full)
//   pop_i/rdata_o  rdata_o is the head entry; pop_i removes it (ignored when empty)
//   full_o/empty_o occupancy flags, derived from the registered count
//   count_o        number of stored entries
// Flags come straight from registers, so a push becomes visible to the reader one cycle later.
module uart_tx_fifo #(
   parameter int Depth = 8,
   parameter int Width = 8,
   localparam int PtrW = $clog2(Depth),
   localparam int CntW = $clog2(Depth) + 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [Width-1:0] wdata_i,
   input  logic             pop_i,
   output logic [Width-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CntW-1:0]  count_o
);

   logic [Width-1:0] mem_q [Depth];
   logic [Width-1:0] mem_d [Depth];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  count_q, count_d;
   logic             push_ok;
   logic             pop_ok;

   assign full_o  = (count_q == CntW'(Depth));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];

   // Both flags use the pre-update count, so a push on a full FIFO is refused even if a pop
   // frees a slot in the same cycle.
   assign push_ok = push_i & ~full_o;
   assign pop_ok  = pop_i & ~empty_o;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = wdata_i;
         wr_ptr_d        = wr_ptr_q + PtrW'(1);
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      count_d = count_q + CntW'(push_ok) - CntW'(pop_ok);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/uart_tx_device.sv
// Memory-mapped 8N1 UART transmitter on the simple-system bus.
// Ports:
//   clk_i        system clock
//   rst_ni       synchronous active-low reset
//   bus          device slot (uart_tx_if.slave): req/we/be/addr/wdata in, rvalid/rdata/err out
//   uart_tx_o    serial line, idle high
//   irq_o        level interrupt: irq_en and FIFO empty and shifter idle
//   dbg_state_o  current shift FSM state
// Registers, selected by addr[3:2] (upper address bits alias):
//   0 TXDATA  write pushes wdata[7:0] when be[0]; full FIFO drops the byte with err. Reads 0.
//   1 STATUS  [0] full, [1] empty, [2] busy, [11:8] FIFO count. Writes answer err.
//   2 DIV     [15:0] cycles per bit; writing 0 stores 1.
//   3 CTRL    [0] tx_en, [1] irq_en.
module uart_tx_device
   import uart_tx_pkg::*;
#(
   parameter int DataWidth    = 32,
   parameter int AddressWidth = 32,
   parameter int FifoDepth    = 8,
   parameter int ClkDiv       = 16
) (
   input  logic      clk_i,
   input  logic      rst_ni,
   uart_tx_if.slave  bus,
   output logic      uart_tx_o,
   output logic      irq_o,
   output tx_state_e dbg_state_o
);

   localparam int CntW = $clog2(FifoDepth) + 1;

   // FIFO connections
   logic            fifo_push;
   logic            fifo_pop;
   logic            fifo_full;
   logic            fifo_empty;
   logic [CntW-1:0] fifo_count;
   logic [7:0]      fifo_rdata;

   // Bus response and configuration registers
   logic                 rvalid_q, rvalid_d;
   logic [DataWidth-1:0] rdata_q, rdata_d;
   logic                 err_q, err_d;
   logic [15:0]          div_q, div_d;
   logic                 tx_en_q, tx_en_d;
   logic                 irq_en_q, irq_en_d;
   logic [DataWidth-1:0] status_word;

   // Shift FSM
   tx_state_e   state_q, state_d;
   logic [15:0] baud_cnt_q, baud_cnt_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic [7:0]  shift_q, shift_d;
   logic        bit_done;
   logic        start_frame;
   logic        busy;

   // Only addr[3:2] and wdata[15:0] carry meaning for this device.
   logic unused_bus_bits;
   assign unused_bus_bits = ^{bus.addr[AddressWidth-1:4], bus.addr[1:0],
                              bus.wdata[DataWidth-1:16]};

   uart_tx_fifo #(
      .Depth (FifoDepth),
      .Width (8)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (fifo_push),
      .wdata_i (bus.wdata[7:0]),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   // ---------------------------------------------------------------- register decode

   always_comb begin
      status_word                               = '0;
      status_word[STATUS_FULL_BIT]              = fifo_full;
      status_word[STATUS_EMPTY_BIT]             = fifo_empty;
      status_word[STATUS_BUSY_BIT]              = busy;
      status_word[STATUS_COUNT_LSB +: 4]        = 4'(fifo_count);
   end

   always_comb begin
      fifo_push = 1'b0;
      rvalid_d  = bus.req;
      rdata_d   = '0;
      err_d     = 1'b0;
      div_d     = div_q;
      tx_en_d   = tx_en_q;
      irq_en_d  = irq_en_q;
      if (bus.req) begin
         case (bus.addr[3:2])
            REG_TXDATA: begin
               if (bus.we && bus.be[0]) begin
                  if (fifo_full) begin
                     err_d = 1'b1;
                  end else begin
                     fifo_push = 1'b1;
                  end
               end
            end
            REG_STATUS: begin
               if (bus.we) begin
                  err_d = 1'b1;
               end else begin
                  rdata_d = status_word;
               end
            end
            REG_DIV: begin
               if (bus.we) begin
                  // Any enabled lane updates the whole field; be==0 is a silent no-op.
                  if (bus.be != 4'b0000) begin
                     div_d = div_sanitize(bus.wdata[15:0]);
                  end
               end else begin
                  rdata_d[15:0] = div_q;
               end
            end
            default: begin
               if (bus.we) begin
                  if (bus.be != 4'b0000) begin
                     tx_en_d  = bus.wdata[CTRL_TX_EN_BIT];
                     irq_en_d = bus.wdata[CTRL_IRQ_EN_BIT];
                  end
               end else begin
                  rdata_d[CTRL_TX_EN_BIT]  = tx_en_q;
                  rdata_d[CTRL_IRQ_EN_BIT] = irq_en_q;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
         div_q    <= 16'(ClkDiv);
         tx_en_q  <= 1'b1;
         irq_en_q <= 1'b0;
      end else begin
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
         div_q    <= div_d;
         tx_en_q  <= tx_en_d;
         irq_en_q <= irq_en_d;
      end
   end

   assign bus.rvalid = rvalid_q;
   assign bus.rdata  = rdata_q;
   assign bus.err    = err_q;

   // ---------------------------------------------------------------- shift FSM: state register

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         baud_cnt_q <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
      end else begin
         state_q    <= state_d;
         baud_cnt_q <= baud_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
      end
   end

   // ---------------------------------------------------------------- shift FSM: next state

   // The baud counter is loaded with DIV at the start of every bit and the bit ends when it
   // reaches 1, so each bit lasts exactly DIV cycles. Because DIV is only sampled at a load, a
   // mid-frame DIV write takes effect from the next bit boundary.
   assign bit_done    = (baud_cnt_q <= 16'd1);
   assign start_frame = tx_en_q & ~fifo_empty;

   always_comb begin
      state_d    = state_q;
      baud_cnt_d = baud_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      fifo_pop   = 1'b0;
      if ((state_q != IDLE) && !bit_done) begin
         baud_cnt_d = baud_cnt_q - 16'd1;
      end
      case (state_q)
         IDLE: begin
            if (start_frame) begin
               state_d    = START;
               fifo_pop   = 1'b1;
               shift_d    = fifo_rdata;
               baud_cnt_d = div_q;
            end
         end
         START: begin
            if (bit_done) begin
               state_d    = DATA;
               bit_cnt_d  = 3'd0;
               baud_cnt_d = div_q;
            end
         end
         DATA: begin
            if (bit_done) begin
               baud_cnt_d = div_q;
               shift_d    = shift_q >> 1;
               if (bit_cnt_q == 3'd7) begin
                  state_d = STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end
         end
         STOP: begin
            if (bit_done) begin
               // Chain straight into the next start bit so back-to-back frames have no gap.
               if (start_frame) begin
                  state_d    = START;
                  fifo_pop   = 1'b1;
                  shift_d    = fifo_rdata;
                  baud_cnt_d = div_q;
               end else begin
                  state_d    = IDLE;
                  baud_cnt_d = '0;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------- shift FSM: outputs

   always_comb begin
      uart_tx_o = 1'b1;
      busy      = (state_q != IDLE);
      case (state_q)
         START:   uart_tx_o = 1'b0;
         DATA:    uart_tx_o = shift_q[0];
         default: uart_tx_o = 1'b1;
      endcase
      // Built only from registered state, so a push in the same cycle cannot glitch it.
      irq_o = irq_en_q & fifo_empty & ~busy;
   end

   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_tx_device.sv
module tb_uart_tx_device;
   import uart_tx_pkg::*;

   // ---------------------------------------------------------------- clock / reset
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   uart_tx_if #(.DataWidth(32), .AddressWidth(32)) bus ();
   logic      uart_tx;
   logic      irq;
   tx_state_e dbg_state;

   uart_tx_device #(
      .DataWidth    (32),
      .AddressWidth (32),
      .FifoDepth    (8),
      .ClkDiv       (16)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .bus         (bus),
      .uart_tx_o   (uart_tx),
      .irq_o       (irq),
      .dbg_state_o (dbg_state)
   );

   // ---------------------------------------------------------------- scoreboard state
   int errors = 0;
   int checks = 0;
   int cur_div = 16;
   logic [7:0]  exp_q[$];
   logic [7:0]  rx_q[$];
   logic        rx_stop_q[$];
   int unsigned start_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Reference serial receiver: samples each bit in its middle using the bit period the bench
   // has programmed, and logs the first cycle of every start bit.
   logic [7:0] mon_byte;
   initial begin
      forever begin
         @(posedge clk); #1;
         if (rst_n === 1'b1 && uart_tx === 1'b0) begin
            start_q.push_back(cyc);
            repeat (cur_div / 2) begin @(posedge clk); #1; end
            for (int b = 0; b < 8; b++) begin
               repeat (cur_div) begin @(posedge clk); #1; end
               mon_byte[b] = uart_tx;
            end
            repeat (cur_div) begin @(posedge clk); #1; end
            rx_stop_q.push_back(uart_tx);
            rx_q.push_back(mon_byte);
         end
      end
   end

   // ---------------------------------------------------------------- driver tasks
   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic bus_xfer(input logic we, input logic [3:0] be, input logic [1:0] reg_idx,
                           input logic [31:0] wdata, output logic [31:0] rdata, output logic err);
      bus.req   = 1'b1;
      bus.we    = we;
      bus.be    = be;
      bus.addr  = ($urandom() & 32'hFFFF_FFF0) | {28'd0, reg_idx, 2'b00};
      bus.wdata = wdata;
      tick();
      bus.req = 1'b0;
      bus.we  = 1'b0;
      bus.be  = 4'b0000;
      check("rvalid", {31'd0, bus.rvalid}, 32'd1);
      rdata = bus.rdata;
      err   = bus.err;
   endtask

   task automatic write_reg(input logic [1:0] reg_idx, input logic [31:0] data,
                            input logic [3:0] be, input logic exp_err, input string tag);
      logic [31:0] rd;
      logic        er;
      bus_xfer(1'b1, be, reg_idx, data, rd, er);
      check({tag, "_err"}, {31'd0, er}, {31'd0, exp_err});
   endtask

   task automatic read_reg(input logic [1:0] reg_idx, input logic [31:0] exp, input string tag);
      logic [31:0] rd;
      logic        er;
      bus_xfer(1'b0, 4'b1111, reg_idx, 32'd0, rd, er);
      check(tag, rd, exp);
      check({tag, "_err"}, {31'd0, er}, 32'd0);
   endtask

   function automatic logic [31:0] status_word(input int count, input bit busy);
      logic [31:0] w;
      w       = '0;
      w[11:8] = count[3:0];
      w[2]    = busy;
      w[1]    = (count == 0);
      w[0]    = (count == 8);
      return w;
   endfunction

   task automatic wait_rx(input int budget);
      int n;
      n = 0;
      while (rx_q.size() < exp_q.size() && n < budget) begin tick(); n++; end
      check("rx_count", rx_q.size(), exp_q.size());
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while (dbg_state !== IDLE && n < budget) begin tick(); n++; end
      check("wait_idle", 32'(dbg_state), 32'(IDLE));
   endtask

   task automatic compare_rx(input string tag);
      logic [7:0] e, a;
      logic       s;
      while (exp_q.size() > 0 && rx_q.size() > 0) begin
         e = exp_q.pop_front();
         a = rx_q.pop_front();
         s = rx_stop_q.pop_front();
         check({tag, "_byte"}, {24'd0, a}, {24'd0, e});
         check({tag, "_stop"}, {31'd0, s}, 32'd1);
      end
      exp_q.delete();
      rx_q.delete();
      rx_stop_q.delete();
   endtask

   // ---------------------------------------------------------------- directed sequence
   initial begin
      logic [7:0]  b;
      logic [9:0]  frame;
      int          lat;
      int          model_cnt;
      int          n;
      int          div;
      int unsigned rise_cyc;
      logic [31:0] rd;
      logic        er;

      bus.req = 1'b0; bus.we = 1'b0; bus.be = 4'b0000; bus.addr = '0; bus.wdata = '0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Reset state
      check("rst_tx", {31'd0, uart_tx}, 32'd1);
      check("rst_irq", {31'd0, irq}, 32'd0);
      check("rst_rvalid", {31'd0, bus.rvalid}, 32'd0);
      read_reg(REG_STATUS, 32'h0000_0002, "rst_status");
      read_reg(REG_DIV, 32'd16, "rst_div");
      read_reg(REG_CTRL, 32'd1, "rst_ctrl");
      read_reg(REG_TXDATA, 32'd0, "txdata_read");

      // Register corner cases
      write_reg(REG_STATUS, 32'h1234, 4'b1111, 1'b1, "status_write");
      write_reg(REG_DIV, 32'd0, 4'b1111, 1'b0, "div_zero");
      read_reg(REG_DIV, 32'd1, "div_zero_read");
      write_reg(REG_DIV, 32'd7, 4'b0000, 1'b0, "div_be0");
      read_reg(REG_DIV, 32'd1, "div_be0_read");
      write_reg(REG_CTRL, 32'd0, 4'b1111, 1'b0, "ctrl_off");
      write_reg(REG_TXDATA, 32'hAA, 4'b1110, 1'b0, "txdata_be0");
      read_reg(REG_STATUS, status_word(0, 0), "txdata_be0_status");
      write_reg(REG_CTRL, 32'd1, 4'b1111, 1'b0, "ctrl_on");

      // Exact line waveform for 0x55 at DIV=4
      write_reg(REG_DIV, 32'd4, 4'b0011, 1'b0, "div4");
      cur_div = 4;
      b = 8'h55;
      frame = {1'b1, b, 1'b0};
      write_reg(REG_TXDATA, {24'd0, b}, 4'b0001, 1'b0, "tx55");
      exp_q.push_back(b);
      lat = 0;
      while (uart_tx !== 1'b0 && lat < 10) begin tick(); lat++; end
      check("start_latency", lat, 1);
      for (int i = 0; i < 40; i++) begin
         check($sformatf("wave_%0d", i), {31'd0, uart_tx}, {31'd0, frame[i / 4]});
         tick();
      end
      check("wave_idle", {31'd0, uart_tx}, 32'd1);
      read_reg(REG_STATUS, status_word(0, 0), "after55_status");
      wait_rx(100);
      compare_rx("rx55");

      // Overflow with tx_en=0, then drain
      write_reg(REG_CTRL, 32'd0, 4'b1111, 1'b0, "ctrl_off2");
      write_reg(REG_DIV, 32'd16, 4'b1111, 1'b0, "div16");
      cur_div = 16;
      model_cnt = 0;
      for (int i = 0; i < 9; i++) begin
         b = 8'($urandom());
         bus_xfer(1'b1, 4'b0001, REG_TXDATA, {24'd0, b}, rd, er);
         check($sformatf("fill_err_%0d", i), {31'd0, er}, (model_cnt < 8) ? 32'd0 : 32'd1);
         if (model_cnt < 8) begin
            exp_q.push_back(b);
            model_cnt++;
         end
      end
      read_reg(REG_STATUS, status_word(8, 0), "full_status");
      write_reg(REG_CTRL, 32'd1, 4'b1111, 1'b0, "ctrl_on2");
      wait_rx(3000);
      compare_rx("rx_full");
      wait_idle(200);
      read_reg(REG_STATUS, status_word(0, 0), "drained_status");

      // Back-to-back bursts: the first at DIV=2, then random periods
      for (int r = 0; r < 4; r++) begin
         div = (r == 0) ? 2 : $urandom_range(1, 5);
         n   = (r == 0) ? 2 : $urandom_range(2, 6);
         write_reg(REG_DIV, div, 4'b1111, 1'b0, "burst_div");
         cur_div = div;
         start_q.delete();
         for (int i = 0; i < n; i++) begin
            b = 8'($urandom());
            write_reg(REG_TXDATA, {24'd0, b}, 4'b0001, 1'b0, "burst_push");
            exp_q.push_back(b);
         end
         wait_rx(2000);
         check("burst_starts", start_q.size(), n);
         if (start_q.size() == n) begin
            for (int k = 1; k < n; k++) begin
               check($sformatf("burst%0d_gap%0d", r, k), start_q[k] - start_q[k-1], 10 * div);
            end
         end
         compare_rx($sformatf("burst%0d", r));
         wait_idle(200);
      end

      // Interrupt timing
      write_reg(REG_DIV, 32'd3, 4'b1111, 1'b0, "irq_div");
      cur_div = 3;
      write_reg(REG_CTRL, 32'd3, 4'b1111, 1'b0, "irq_en");
      check("irq_idle", {31'd0, irq}, 32'd1);
      start_q.delete();
      b = 8'($urandom());
      write_reg(REG_TXDATA, {24'd0, b}, 4'b0001, 1'b0, "irq_push");
      exp_q.push_back(b);
      check("irq_drop_on_push", {31'd0, irq}, 32'd0);
      n = 0;
      while (irq !== 1'b1 && n < 200) begin tick(); n++; end
      rise_cyc = cyc;
      check("irq_rise_seen", {31'd0, irq}, 32'd1);
      if (start_q.size() > 0) begin
         check("irq_rise_cycle", rise_cyc, start_q[0] + 30);
      end
      check("irq_rise_state", 32'(dbg_state), 32'(IDLE));
      wait_rx(100);
      compare_rx("rx_irq");
      write_reg(REG_TXDATA, 32'h3C, 4'b0001, 1'b0, "irq_push2");
      exp_q.push_back(8'h3C);
      check("irq_drop2", {31'd0, irq}, 32'd0);
      wait_rx(200);
      compare_rx("rx_irq2");
      wait_idle(100);
      write_reg(REG_CTRL, 32'd1, 4'b1111, 1'b0, "irq_dis");
      check("irq_disabled", {31'd0, irq}, 32'd0);

      // Reset in the middle of a frame's data bits
      write_reg(REG_DIV, 32'd8, 4'b1111, 1'b0, "rst_div8");
      cur_div = 8;
      write_reg(REG_TXDATA, 32'h00, 4'b0001, 1'b0, "rst_push");
      lat = 0;
      while (uart_tx !== 1'b0 && lat < 10) begin tick(); lat++; end
      repeat (8 + 12) tick();
      check("pre_rst_state", 32'(dbg_state), 32'(DATA));
      check("pre_rst_line", {31'd0, uart_tx}, 32'd0);
      rst_n = 1'b0;
      tick();
      check("rst_mid_line", {31'd0, uart_tx}, 32'd1);
      check("rst_mid_irq", {31'd0, irq}, 32'd0);
      rst_n = 1'b1;
      read_reg(REG_STATUS, 32'h0000_0002, "rst_mid_status");
      read_reg(REG_DIV, 32'd16, "rst_mid_div");
      read_reg(REG_CTRL, 32'd1, "rst_mid_ctrl");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
